// File: rtl/arb_mux_reg_pkg.sv
// Shared constants and types for the arbitrating register multiplexer.
package arb_mux_reg_pkg;

  localparam logic ArbModeRr    = 1'b0;
  localparam logic ArbModeFixed = 1'b1;

  // Next round-robin pointer: one past the winner, wrapping at N.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Combinational arbiter: round-robin from ptr_i, or fixed lowest-index priority.
module arb_mux_reg_rr_arbiter
  import arb_mux_reg_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned SelW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [SelW-1:0] ptr_i,
  input  logic            mode_i,
  output logic [N-1:0]    grant_o,
  output logic [SelW-1:0] grant_idx_o,
  output logic            any_o
);

  int unsigned base;
  int unsigned idx;
  int unsigned j;

  // Scan starting at the rotation base; the first hit, rotated back, is the winner.
  always_comb begin
    base        = (mode_i == ArbModeFixed) ? 0 : int'(ptr_i);
    idx         = 0;
    j           = 0;
    any_o       = 1'b0;
    grant_o     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (base + i) % N;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx   = j;
      end
    end
    grant_idx_o = SelW'(idx);
    if (any_o) grant_o[idx] = 1'b1;
  end

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel arbitrating multiplexer with a registered output stage and valid/ready handshakes.
module arb_mux_reg
  import arb_mux_reg_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 16,
  parameter int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   inp,
  input  logic [N-1:0]     inp_valid,
  output logic [N-1:0]     inp_ready,
  input  logic             prio_mode,
  output logic [W-1:0]     out,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [W-1:0]     out_q, out_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             any_req;
  logic             load_en;
  logic             accept;

  arb_mux_reg_rr_arbiter #(
    .N    (N),
    .SelW (SEL_W)
  ) u_arbiter (
    .req_i       (inp_valid),
    .ptr_i       (ptr_q),
    .mode_i      (prio_mode),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (any_req)
  );

  assign load_en = !valid_q || out_ready;
  assign accept  = load_en && any_req;

  // Ready is gated by reset so no producer sees a handshake while held in reset.
  assign inp_ready = (rst_n && accept) ? grant : '0;

  always_comb begin
    out_d   = out_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (accept) begin
      out_d   = inp[grant_idx*W +: W];
      sel_d   = grant_idx;
      valid_d = 1'b1;
      if (prio_mode == ArbModeRr) ptr_d = SEL_W'(next_ptr(int'(grant_idx), N));
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      out_q   <= out_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Randomised and directed checks of arb_mux_reg against a behavioural arbitration model.
module tb_arb_mux_reg;

  localparam int N = 8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] inp;
  logic [N-1:0]   inp_valid;
  logic [N-1:0]   inp_ready;
  logic           prio_mode;
  logic [W-1:0]   out;
  logic [2:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_ptr   = 0;
  int         m_sel   = 0;
  logic [W-1:0] m_out = '0;
  logic       m_valid = 1'b0;

  always #5 clk = ~clk;

  arb_mux_reg #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp       (inp),
    .inp_valid (inp_valid),
    .inp_ready (inp_ready),
    .prio_mode (prio_mode),
    .out       (out),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Winner per the arbitration rules, or -1 when no channel is valid.
  function automatic int winner();
    int base;
    base = prio_mode ? 0 : m_ptr;
    for (int k = 0; k < N; k++) begin
      if (inp_valid[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  // Inputs are already driven; check ready, clock once, update model, check outputs.
  task automatic step();
    int         g;
    bit         load;
    logic [N-1:0] exp_rdy;
    #1;
    g       = winner();
    load    = !m_valid || out_ready;
    exp_rdy = '0;
    if (rst_n && load && g >= 0) exp_rdy[g] = 1'b1;
    check("inp_ready", 32'(inp_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_out   = '0;
      m_sel   = 0;
      m_ptr   = 0;
    end else if (load && g >= 0) begin
      m_out   = inp[g*W +: W];
      m_sel   = g;
      m_valid = 1'b1;
      if (!prio_mode) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_sel", 32'(out_sel), 32'(m_sel));
    check("out", 32'(out), 32'(m_out));
  endtask

  initial begin
    rst_n     = 1'b0;
    prio_mode = 1'b0;
    out_ready = 1'b1;
    inp_valid = '1;
    for (int k = 0; k < N; k++) inp[k*W +: W] = W'(16'h1000 + k);

    // Reset with every channel requesting
    @(posedge clk);
    #1;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);

    // Round-robin fairness: 0..7 then 0
    rst_n = 1'b1;
    for (int k = 0; k < N + 1; k++) begin
      step();
      check("rr_seq", 32'(out_sel), 32'(k % N));
      check("rr_data", 32'(out), 32'(16'h1000 + (k % N)));
    end

    // Fixed priority: ch2 wins while valid, then ch5
    prio_mode = 1'b1;
    inp_valid = 8'b1010_0100;
    for (int k = 0; k < 4; k++) begin
      step();
      check("fixed_sel", 32'(out_sel), 32'd2);
    end
    inp_valid = 8'b1010_0000;
    step();
    check("fixed_next", 32'(out_sel), 32'd5);

    // Backpressure holding a ch3 word
    prio_mode        = 1'b0;
    inp_valid        = 8'b0000_1000;
    inp[3*W +: W]    = 16'hBEEF;
    step();
    out_ready = 1'b0;
    inp_valid = 8'b0110_0001;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_out", 32'(out), 32'hBEEF);
      check("bp_sel", 32'(out_sel), 32'd3);
    end
    out_ready = 1'b1;
    step();
    check("bp_release", 32'(out_sel), 32'd5);

    // Wrap: grant ch6 puts ptr at 7, so ch7 beats ch0, then ch0
    inp_valid = 8'b0100_0000;
    step();
    inp_valid = 8'b1000_0001;
    step();
    check("wrap_ch7", 32'(out_sel), 32'd7);
    step();
    check("wrap_ch0", 32'(out_sel), 32'd0);

    // Reset mid-stream with a word pending under backpressure
    inp_valid = 8'b0000_0010;
    out_ready = 1'b0;
    step();
    rst_n     = 1'b0;
    inp_valid = '1;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    inp_valid = 8'b0011_0000;
    step();
    check("post_rst_first", 32'(out_sel), 32'd4);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      prio_mode = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      inp_valid = N'($urandom);
      for (int k = 0; k < N; k++) inp[k*W +: W] = W'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
